// File: rtl/packet_arbiter_wrr.sv
// Packet-atomic weighted round-robin arbiter: N flit streams onto one registered output.
// The grant is held from header to last flit. A 2-entry skid buffer drives the output.
module packet_arbiter_wrr #(
  parameter int CHANNEL_NUMBER = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int HEADER_ID      = 0,
  parameter int X_WIDTH        = 2,
  parameter int Y_WIDTH        = 2,
  parameter int LEN_LSB        = 8,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0]   in_data,
  input  logic [CHANNEL_NUMBER*ID_WIDTH-1:0]     in_id,
  input  logic [CHANNEL_NUMBER-1:0]              in_valid,
  output logic [CHANNEL_NUMBER-1:0]              in_ready,
  input  logic [CHANNEL_NUMBER*WEIGHT_WIDTH-1:0] weight,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic [ID_WIDTH-1:0]                    out_id,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(CHANNEL_NUMBER)-1:0]      grant,
  output logic [X_WIDTH-1:0]                     target_x,
  output logic [Y_WIDTH-1:0]                     target_y,
  output logic                                   proto_err,
  output logic [CHANNEL_NUMBER*CNT_WIDTH-1:0]    pkt_cnt
);

  localparam int GW = $clog2(CHANNEL_NUMBER);
  localparam logic [ID_WIDTH-1:0] HDR = ID_WIDTH'(HEADER_ID);

  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_next;

  logic [WEIGHT_WIDTH-1:0] credits;
  logic [7:0]              left;
  logic                    hdr_phase;
  logic [X_WIDTH-1:0]      tx_q;
  logic [Y_WIDTH-1:0]      ty_q;

  logic [DATA_WIDTH-1:0]   e0_data, e1_data;
  logic [ID_WIDTH-1:0]     e0_id, e1_id;
  logic [1:0]              count;
  logic                    full;

  logic [DATA_WIDTH-1:0]   own_data;
  logic [ID_WIDTH-1:0]     own_id;
  logic                    own_valid;
  logic [7:0]              own_len;
  logic [CHANNEL_NUMBER-1:0] eligible;

  logic                    pick_found, drop_found, drop, xfer, hdr_xfer;
  logic [GW-1:0]           pick, drop_sel;
  logic [WEIGHT_WIDTH-1:0] pick_w, reload;

  assign own_data  = in_data[grant*DATA_WIDTH +: DATA_WIDTH];
  assign own_id    = in_id[grant*ID_WIDTH +: ID_WIDTH];
  assign own_valid = in_valid[grant];
  assign own_len   = own_data[LEN_LSB +: 8];
  assign full      = (count == 2'd2);
  assign hdr_xfer  = xfer && hdr_phase;

  for (genvar c = 0; c < CHANNEL_NUMBER; c++) begin : g_elig
    assign eligible[c] = in_valid[c] && (in_id[c*ID_WIDTH +: ID_WIDTH] == HDR);
  end

  // Owner keeps priority while it has credits; otherwise scan starts after it.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick       = '0;
    drop_found = 1'b0;
    drop_sel   = '0;
    if (credits != '0 && eligible[grant]) begin
      pick_found = 1'b1;
      pick       = grant;
    end else begin
      for (int i = 1; i <= CHANNEL_NUMBER; i++) begin
        idx = (int'(grant) + i) % CHANNEL_NUMBER;
        if (!pick_found && eligible[idx]) begin
          pick_found = 1'b1;
          pick       = GW'(idx);
        end
      end
    end
    for (int c = CHANNEL_NUMBER - 1; c >= 0; c--) begin
      if (in_valid[c] && !eligible[c]) begin
        drop_found = 1'b1;
        drop_sel   = GW'(c);
      end
    end
  end

  assign pick_w = weight[pick*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign reload = (pick_w == '0) ? '0 : pick_w - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = '0;
    xfer       = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = LOCKED;
        end else if (drop_found) begin
          drop               = 1'b1;
          in_ready[drop_sel] = 1'b1;
        end
      end
      LOCKED: begin
        in_ready[grant] = !full;
        xfer            = own_valid && !full;
        if (xfer && (hdr_phase ? (own_len == 8'd0) : (left == 8'd1)))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Arbitration, packet tracking and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      credits   <= '0;
      left      <= '0;
      hdr_phase <= 1'b0;
      tx_q      <= '0;
      ty_q      <= '0;
      proto_err <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      if (state == IDLE && pick_found) begin
        grant     <= pick;
        // A fresh turn (new owner or exhausted credits) reloads from the weight.
        credits   <= (pick != grant || credits == '0) ? reload : credits - 1'b1;
        hdr_phase <= 1'b1;
      end
      if (hdr_xfer) begin
        left      <= own_len;
        tx_q      <= own_data[Y_WIDTH +: X_WIDTH];
        ty_q      <= own_data[0 +: Y_WIDTH];
        hdr_phase <= 1'b0;
      end else if (xfer) begin
        left <= left - 1'b1;
      end
      if (drop || (xfer && !hdr_phase && own_id == HDR))
        proto_err <= 1'b1;
      for (int c = 0; c < CHANNEL_NUMBER; c++) begin
        if (hdr_xfer && grant == GW'(c) && pkt_cnt[c*CNT_WIDTH +: CNT_WIDTH] != '1)
          pkt_cnt[c*CNT_WIDTH +: CNT_WIDTH] <= pkt_cnt[c*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
      end
    end
  end

  assign target_x = hdr_xfer ? own_data[Y_WIDTH +: X_WIDTH] : tx_q;
  assign target_y = hdr_xfer ? own_data[0 +: Y_WIDTH] : ty_q;

  // Skid buffer: entry 0 is the output register, entry 1 absorbs one stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= 2'd0;
      e0_data <= '0;
      e0_id   <= '0;
      e1_data <= '0;
      e1_id   <= '0;
    end else begin
      if (xfer && out_valid && out_ready) begin
        if (count == 2'd1) begin
          e0_data <= own_data;
          e0_id   <= own_id;
        end else begin
          e0_data <= e1_data;
          e0_id   <= e1_id;
          e1_data <= own_data;
          e1_id   <= own_id;
        end
      end else if (xfer) begin
        if (count == 2'd0) begin
          e0_data <= own_data;
          e0_id   <= own_id;
        end else begin
          e1_data <= own_data;
          e1_id   <= own_id;
        end
        count <= count + 2'd1;
      end else if (out_valid && out_ready) begin
        e0_data <= e1_data;
        e0_id   <= e1_id;
        count   <= count - 2'd1;
      end
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = e0_data;
  assign out_id    = e0_id;

endmodule

// File: tb/tb_packet_arbiter_wrr.sv
// Bench for packet_arbiter_wrr: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_packet_arbiter_wrr;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int WW = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  logic [N*DW-1:0] in_data;
  logic [N*IW-1:0] in_id;
  logic [N-1:0]    in_valid, in_ready;
  logic [N*WW-1:0] weight;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  logic            out_valid, out_ready;
  logic [2:0]      grant;
  logic [1:0]      target_x, target_y;
  logic            proto_err;
  logic [N*CW-1:0] pkt_cnt;

  packet_arbiter_wrr dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_id(in_id), .in_valid(in_valid),
    .in_ready(in_ready), .weight(weight), .out_data(out_data), .out_id(out_id),
    .out_valid(out_valid), .out_ready(out_ready), .grant(grant), .target_x(target_x),
    .target_y(target_y), .proto_err(proto_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] d; logic [3:0] id;} flit_t;
  typedef struct {int cyc; logic [31:0] d; logic [3:0] id;} log_t;

  flit_t src_q [N][$];
  log_t  out_log[$];
  int    n_chk = 0, n_pass = 0;
  int    cyc = 0;
  int    bubble_pct = 0, ordy_pct = 100;
  bit    ordy_toggle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit          m_locked, m_hdr, m_err;
  int          m_owner, m_credits, m_left, m_tx, m_ty;
  int          m_cnt[N];
  logic [31:0] sk_d[$];
  logic [3:0]  sk_id[$];
  logic [N-1:0] e_ready;
  bit          e_xfer, e_pick_f, e_drop;
  int          e_pick, exp_tx, exp_ty;
  logic [31:0] cur_d;
  logic [3:0]  cur_id;
  bit          hold_pend;
  logic [31:0] hold_d;

  task model_reset();
    m_locked = 0; m_hdr = 0; m_err = 0; m_owner = 0; m_credits = 0; m_left = 0;
    m_tx = 0; m_ty = 0; hold_pend = 0;
    for (int c = 0; c < N; c++) m_cnt[c] = 0;
    sk_d.delete(); sk_id.delete();
  endtask

  task model_eval();
    logic [N-1:0] el;
    e_ready = '0; e_xfer = 0; e_pick_f = 0; e_pick = 0; e_drop = 0;
    for (int c = 0; c < N; c++) el[c] = in_valid[c] && (in_id[c*IW +: IW] == 4'd0);
    if (!m_locked) begin
      if (el != '0) begin
        e_pick_f = 1;
        if (m_credits > 0 && el[m_owner]) e_pick = m_owner;
        else begin
          for (int k = 1; k <= N; k++)
            if (el[(m_owner + k) % N]) begin e_pick = (m_owner + k) % N; break; end
        end
      end else begin
        for (int c = 0; c < N; c++)
          if (in_valid[c]) begin e_drop = 1; e_ready[c] = 1'b1; break; end
      end
    end else begin
      e_ready[m_owner] = (sk_d.size() < 2);
      e_xfer = in_valid[m_owner] && e_ready[m_owner];
    end
    cur_d  = in_data[m_owner*DW +: DW];
    cur_id = in_id[m_owner*IW +: IW];
    exp_tx = (e_xfer && m_hdr) ? int'(cur_d[3:2]) : m_tx;
    exp_ty = (e_xfer && m_hdr) ? int'(cur_d[1:0]) : m_ty;
  endtask

  task model_update();
    int w;
    if (sk_d.size() > 0 && out_ready) begin
      void'(sk_d.pop_front()); void'(sk_id.pop_front());
    end
    if (e_xfer) begin
      sk_d.push_back(cur_d); sk_id.push_back(cur_id);
      if (m_hdr) begin
        m_hdr = 0; m_left = int'(cur_d[15:8]);
        m_tx = int'(cur_d[3:2]); m_ty = int'(cur_d[1:0]);
        if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
        if (m_left == 0) m_locked = 0;
      end else begin
        if (cur_id == 4'd0) m_err = 1;
        m_left--;
        if (m_left == 0) m_locked = 0;
      end
    end else if (e_pick_f) begin
      w = int'(weight[e_pick*WW +: WW]);
      if (w == 0) w = 1;
      if (e_pick != m_owner || m_credits == 0) m_credits = w - 1;
      else m_credits--;
      m_owner = e_pick; m_locked = 1; m_hdr = 1;
    end
    if (e_drop) m_err = 1;
  endtask

  // Compare process: sample at negedge, advance model at posedge
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) begin
        model_eval();
        chk("in_ready", longint'(in_ready), longint'(e_ready));
        chk("out_valid", longint'(out_valid), longint'(sk_d.size() > 0));
        if (sk_d.size() > 0) begin
          chk("out_data", longint'(out_data), longint'(sk_d[0]));
          chk("out_id", longint'(out_id), longint'(sk_id[0]));
        end
        chk("grant", longint'(grant), longint'(m_owner));
        chk("proto_err", longint'(proto_err), longint'(m_err));
        for (int c = 0; c < N; c++)
          chk("pkt_cnt", longint'(pkt_cnt[c*CW +: CW]), longint'(m_cnt[c]));
        chk("target_x", longint'(target_x), longint'(exp_tx));
        chk("target_y", longint'(target_y), longint'(exp_ty));
        if (hold_pend) begin
          chk("hold_valid", longint'(out_valid), 64'd1);
          chk("hold_data", longint'(out_data), longint'(hold_d));
        end
        hold_pend = out_valid && !out_ready;
        hold_d    = out_data;
        if (out_valid && out_ready) out_log.push_back('{cyc, out_data, out_id});
      end
      @(posedge clk);
      if (rst) model_reset();
      else begin model_eval(); model_update(); end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    logic [N-1:0] f;
    @(negedge clk);
    f = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (f[c]) begin void'(src_q[c].pop_front()); in_valid[c] = 1'b0; end
      if (!in_valid[c] && src_q[c].size() > 0 && $urandom_range(99) >= bubble_pct) begin
        in_valid[c] = 1'b1;
        in_data[c*DW +: DW] = src_q[c][0].d;
        in_id[c*IW +: IW]   = src_q[c][0].id;
      end
    end
    if (ordy_toggle) out_ready = ~out_ready;
    else out_ready = ($urandom_range(99) < ordy_pct);
  endtask

  task automatic add_flit(input int c, input logic [31:0] d, input logic [3:0] id);
    src_q[c].push_back('{d, id});
  endtask

  task automatic add_pkt(input int c, input int len);
    logic [3:0] ch;
    ch = 4'(c);
    add_flit(c, {ch, 12'($urandom), 8'(len), 8'($urandom)}, 4'd0);
    for (int i = 0; i < len; i++)
      add_flit(c, {ch, 28'($urandom)}, 4'($urandom_range(1, 15)));
  endtask

  function automatic bit srcs_empty();
    for (int c = 0; c < N; c++) if (src_q[c].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_drain(input int budget);
    int k = 0, idle = 0;
    while (k < budget && idle < 4) begin
      tick(); k++;
      if (srcs_empty() && in_valid == '0 && !out_valid) idle++;
      else idle = 0;
    end
    chk("drain", longint'(idle >= 4), 64'd1);
  endtask

  task automatic chk_chan_seq(input string nm, input int exp[]);
    int hs[$];
    foreach (out_log[i]) if (nm != "seq_all" ? out_log[i].id == 4'd0 : 1'b1)
      hs.push_back(int'(out_log[i].d[31:28]));
    chk({nm, "_len"}, longint'(hs.size() >= exp.size()), 64'd1);
    foreach (exp[i]) if (i < hs.size()) chk(nm, longint'(hs[i]), longint'(exp[i]));
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish, required finish before 5ms");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_d[4];
    int t0;
    rst = 1'b1; in_valid = '0; in_data = '0; in_id = '0; out_ready = 1'b1;
    weight = {N{4'd1}};
    repeat (3) tick();
    chk("rst_out_valid", longint'(out_valid), 64'd0);
    chk("rst_grant", longint'(grant), 64'd0);
    chk("rst_proto_err", longint'(proto_err), 64'd0);
    chk("rst_in_ready", longint'(in_ready), 64'd0);
    chk("rst_out_data", longint'(out_data), 64'd0);
    for (int c = 0; c < N; c++) chk("rst_pkt_cnt", longint'(pkt_cnt[c*CW +: CW]), 64'd0);
    rst = 1'b0;
    tick();

    // single packet on ch2: header LEN=3 target (2,1), three body flits
    out_log.delete();
    exp_d = '{32'h2000_0309, 32'h2000_0001, 32'h2000_0002, 32'h2000_0003};
    add_flit(2, exp_d[0], 4'd0);
    for (int i = 1; i < 4; i++) add_flit(2, exp_d[i], 4'd1);
    tick();
    t0 = cyc;
    repeat (8) tick();
    chk("t1_count", longint'(out_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) if (i < out_log.size()) begin
      chk("t1_cycle", longint'(out_log[i].cyc), longint'(t0 + 2 + i));
      chk("t1_data", longint'(out_log[i].d), longint'(exp_d[i]));
    end
    chk("t1_grant", longint'(grant), 64'd2);
    chk("t1_target_x", longint'(target_x), 64'd2);
    chk("t1_target_y", longint'(target_y), 64'd1);
    chk("t1_pkt_cnt2", longint'(pkt_cnt[2*CW +: CW]), 64'd1);

    // weighted turns: ch0 weight 2, ch1 weight 1, both saturated with LEN=0 packets
    out_log.delete();
    weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
    for (int i = 0; i < 5; i++) add_flit(0, 32'h0000_0000, 4'd0);
    for (int i = 0; i < 3; i++) add_flit(1, 32'h1000_0000, 4'd0);
    wait_drain(300);
    chk_chan_seq("t2_order", '{0, 0, 1, 0, 0, 1});
    weight = {N{4'd1}};

    // lock: ch3 header waits until ch1 packet completes
    out_log.delete();
    add_flit(1, 32'h1000_0200, 4'd0);
    add_flit(1, 32'h1000_0011, 4'd2);
    add_flit(1, 32'h1000_0012, 4'd2);
    tick();
    add_flit(3, 32'h3000_0100, 4'd0);
    add_flit(3, 32'h3000_0021, 4'd4);
    wait_drain(300);
    chk_chan_seq("seq_all", '{1, 1, 1, 3, 3});

    // out_ready toggling during a LEN=5 packet
    out_log.delete();
    ordy_toggle = 1;
    add_flit(0, 32'h0000_0500, 4'd0);
    for (int i = 0; i < 5; i++) add_flit(0, 32'h0000_00A0 + i, 4'd7);
    wait_drain(300);
    ordy_toggle = 0;
    chk("t4_count", longint'(out_log.size()), 64'd6);
    for (int i = 1; i < 6; i++) if (i < out_log.size())
      chk("t4_data", longint'(out_log[i].d), longint'(32'h0000_00A0 + i - 1));

    // stray body flit in IDLE is dropped and flags a sticky error
    out_log.delete();
    chk("t5_err_before", longint'(proto_err), 64'd0);
    add_flit(4, 32'h4000_0055, 4'd5);
    repeat (4) tick();
    chk("t5_err_set", longint'(proto_err), 64'd1);
    chk("t5_consumed", longint'(src_q[4].size()), 64'd0);
    chk("t5_nothing_out", longint'(out_log.size()), 64'd0);
    repeat (5) tick();
    chk("t5_err_sticky", longint'(proto_err), 64'd1);

    // reset in the middle of a packet
    add_flit(0, 32'h0000_0500, 4'd0);
    for (int i = 0; i < 5; i++) add_flit(0, 32'h0000_00B0 + i, 4'd6);
    repeat (5) tick();
    rst = 1'b1;
    for (int c = 0; c < N; c++) src_q[c].delete();
    in_valid = '0;
    #1;
    chk("t6_out_valid_async", longint'(out_valid), 64'd0);
    tick();
    chk("t6_grant", longint'(grant), 64'd0);
    chk("t6_proto_err", longint'(proto_err), 64'd0);
    chk("t6_out_valid", longint'(out_valid), 64'd0);
    for (int c = 0; c < N; c++) chk("t6_pkt_cnt", longint'(pkt_cnt[c*CW +: CW]), 64'd0);
    rst = 1'b0;
    out_log.delete();
    add_flit(3, 32'h3000_0106, 4'd0);
    add_flit(3, 32'h3000_0031, 4'd2);
    wait_drain(300);
    chk("t6_new_grant", longint'(grant), 64'd3);
    chk("t6_new_cnt", longint'(pkt_cnt[3*CW +: CW]), 64'd1);
    chk("t6_new_flits", longint'(out_log.size()), 64'd2);

    // header id inside a packet is forwarded as body and flags an error
    out_log.delete();
    chk("t7_err_before", longint'(proto_err), 64'd0);
    add_flit(1, 32'h1000_0200, 4'd0);
    add_flit(1, 32'h1000_0BAD, 4'd0);
    add_flit(1, 32'h1000_0042, 4'd3);
    wait_drain(300);
    chk("t7_err", longint'(proto_err), 64'd1);
    chk("t7_count", longint'(out_log.size()), 64'd3);
    if (out_log.size() > 1) chk("t7_mid_data", longint'(out_log[1].d), 64'h1000_0BAD);

    // randomized traffic, random weights (0 included), bubbles and backpressure
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < N; c++) weight[c*WW +: WW] = 4'($urandom_range(0, 15));
      bubble_pct = (r == 2) ? 0 : 30;
      ordy_pct   = (r == 2) ? 100 : 60;
      for (int c = 0; c < N; c++)
        for (int p = 0; p < 8; p++) add_pkt(c, $urandom_range(0, 6));
      wait_drain(20000);
    end
    ordy_pct = 100;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
